// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multicycle MIPS main control: states, opcodes, ALU_Op codes
// and the control word produced by the state decoder.
package multicycle_main_control_pkg;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StRExec  = 4'd7,
        StRWb    = 4'd8,
        StBeq    = 4'd9,
        StJump   = 4'd10,
        StAddiEx = 4'd11,
        StTrap   = 4'd12,
        StAddiWb = 4'd13
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    // Shared with the ALU control decoder.
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] SrcBRt     = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Control/datapath bundle: the controller (master) drives every enable and select,
// the datapath (slave) supplies the opcode and memory handshake.
interface multicycle_main_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       instr_retire;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
               instr_retire, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
               instr_retire, state
    );
endinterface

// File: rtl/multicycle_main_control_decode.sv
// Combinational state -> control word decoder; only FETCH looks at the memory handshake.
module multicycle_main_control_decode
    import multicycle_main_control_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    output ctrl_word_t ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StFetch: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SrcBFour;
                ctrl_o.alu_op    = AluOpAdd;
                ctrl_o.pc_source = PcSrcAlu;
                // PC and IR load only on the cycle the fetch completes.
                ctrl_o.pc_write  = mem_ready_i;
                ctrl_o.ir_write  = mem_ready_i;
            end
            StDecode: begin
                ctrl_o.alu_src_b = SrcBImmSh2;
                ctrl_o.alu_op    = AluOpAdd;
            end
            StMemAdr, StAddiEx: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluOpAdd;
            end
            StMemRd: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.ior_d    = 1'b1;
            end
            StMemWb: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.ior_d     = 1'b1;
            end
            StRExec: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBRt;
                ctrl_o.alu_op    = AluOpFunct;
            end
            StRWb: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            StBeq: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SrcBRt;
                ctrl_o.alu_op        = AluOpSub;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PcSrcAluOut;
            end
            StJump: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PcSrcJump;
            end
            StAddiWb: begin
                ctrl_o.reg_write = 1'b1;
            end
            StTrap: begin
                ctrl_o.illegal_op = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control: state register, opcode-driven next-state logic and
// instruction-retire pulse; control outputs come from the state decoder.
module multicycle_main_control
    import multicycle_main_control_pkg::*;
#(
    parameter bit MemWaitEn = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_main_control_if.master  bus
);

    state_e     state_q, state_d;
    ctrl_word_t ctrl;
    logic       mem_ready_eff;

    assign mem_ready_eff = MemWaitEn ? bus.mem_ready : 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (mem_ready_eff) state_d = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OpRType:    state_d = StRExec;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:      state_d = StBeq;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
                    default:    state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                if (bus.opcode == OpLw)      state_d = StMemRd;
                else if (bus.opcode == OpSw) state_d = StMemWr;
                else                         state_d = StTrap;
            end
            StMemRd:  if (mem_ready_eff) state_d = StMemWb;
            StMemWr:  if (mem_ready_eff) state_d = StFetch;
            StRExec:  state_d = StRWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StRWb, StBeq, StJump, StAddiWb: state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StTrap;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    multicycle_main_control_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready_eff),
        .ctrl_o      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.ior_d         = ctrl.ior_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.state         = state_q;

    // IDLE->FETCH and FETCH stalls are not instruction completions.
    assign bus.instr_retire = (state_q != StIdle) && (state_q != StFetch) &&
                              (state_d == StFetch);

endmodule
